// File: rtl/flash_cache_page_set.sv
// Multi-page flash cache controller: holds a fully-associative tag for each
// page of a shared cache SRAM. It replaces pages in round-robin order and
// fills one page at a time through a single QSPI read engine.
module flash_cache_page_set #(
  parameter int unsigned ADDRESS_SIZE        = 24,
  parameter int unsigned PAGE_COUNT_LOG2     = 3,
  parameter int unsigned WORDS_PER_PAGE_LOG2 = 6,
  localparam int unsigned PAGE_COUNT         = 1 << PAGE_COUNT_LOG2,
  localparam int unsigned SRAM_ADDRESS_SIZE  = PAGE_COUNT_LOG2 + WORDS_PER_PAGE_LOG2,
  localparam int unsigned TAG_SIZE           = ADDRESS_SIZE - WORDS_PER_PAGE_LOG2 - 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         qspi_enable,
  input  logic                         invalidateAll,
  input  logic                         readEnable,
  input  logic [ADDRESS_SIZE-1:0]      readAddress,
  output logic                         wordReady,
  output logic [SRAM_ADDRESS_SIZE-1:0] sramReadAddress,
  output logic [SRAM_ADDRESS_SIZE-1:0] sramWriteAddress,
  output logic                         sramWriteEnable,
  output logic [ADDRESS_SIZE-1:0]      qspi_address,
  output logic                         qspi_changeAddress,
  output logic                         qspi_requestData,
  input  logic                         qspi_readDataValid,
  input  logic                         qspi_initialised,
  input  logic                         qspi_busy,
  output logic [PAGE_COUNT-1:0]        pageValidMask,
  output logic                         busy
);

  localparam int unsigned WORDS_PER_PAGE = 1 << WORDS_PER_PAGE_LOG2;
  localparam int unsigned COUNT_SIZE     = WORDS_PER_PAGE_LOG2 + 1;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    CHANGE_ADDR = 2'd1,
    FILL        = 2'd2
  } stateT;

  stateT state;
  stateT nextState;

  logic [TAG_SIZE-1:0]        tag       [PAGE_COUNT];
  logic [COUNT_SIZE-1:0]      fillCount [PAGE_COUNT];
  logic [PAGE_COUNT-1:0]      tagValid;
  logic [PAGE_COUNT_LOG2-1:0] victim;
  logic [PAGE_COUNT_LOG2-1:0] fillPage;

  logic [TAG_SIZE-1:0]            requestTag;
  logic [WORDS_PER_PAGE_LOG2-1:0] wordIndex;
  logic [PAGE_COUNT_LOG2-1:0]     hitPage;
  logic                           hitAny;
  logic                           cacheOn;
  logic                           abortFill;
  logic                           allocate;
  logic                           wordWrite;
  logic                           fillDone;
  logic [1:0]                     unusedByteOffset;

  assign requestTag       = readAddress[ADDRESS_SIZE-1 -: TAG_SIZE];
  assign wordIndex        = readAddress[WORDS_PER_PAGE_LOG2+1:2];
  assign unusedByteOffset = readAddress[1:0];
  assign cacheOn          = qspi_enable && qspi_initialised;
  // A fill in flight is dropped the moment the cache is switched off.
  assign abortFill        = (state != IDLE) && !qspi_enable;

  // Fully-associative lookup; the lowest matching page wins.
  always_comb begin
    hitAny  = 1'b0;
    hitPage = '0;
    for (int p = int'(PAGE_COUNT) - 1; p >= 0; p--) begin
      if (tagValid[p] && (tag[p] == requestTag)) begin
        hitAny  = 1'b1;
        hitPage = PAGE_COUNT_LOG2'(p);
      end
    end
  end

  // Read-side and SRAM/QSPI address outputs (combinational by design).
  assign wordReady        = cacheOn && readEnable && hitAny &&
                            ({1'b0, wordIndex} < fillCount[hitPage]);
  assign sramReadAddress  = {hitPage, wordIndex};
  assign sramWriteAddress = {fillPage, fillCount[fillPage][WORDS_PER_PAGE_LOG2-1:0]};
  assign sramWriteEnable  = qspi_requestData && qspi_readDataValid && (state == FILL);
  assign qspi_address     = {tag[fillPage], (WORDS_PER_PAGE_LOG2 + 2)'(0)};
  assign pageValidMask    = tagValid;
  assign busy             = (state != IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state and fill-engine control; aborts override everything.
  always_comb begin
    nextState          = state;
    qspi_changeAddress = 1'b0;
    qspi_requestData   = 1'b0;
    allocate           = 1'b0;
    wordWrite          = 1'b0;
    fillDone           = 1'b0;
    case (state)
      IDLE: begin
        if (readEnable && !hitAny && cacheOn) begin
          allocate  = 1'b1;
          nextState = CHANGE_ADDR;
        end
      end
      CHANGE_ADDR: begin
        qspi_changeAddress = !qspi_busy;
        if (!qspi_busy) begin
          nextState = FILL;
        end
      end
      FILL: begin
        qspi_requestData = 1'b1;
        if (qspi_readDataValid) begin
          wordWrite = 1'b1;
          if (fillCount[fillPage] == COUNT_SIZE'(WORDS_PER_PAGE - 1)) begin
            fillDone  = 1'b1;
            nextState = IDLE;
          end
        end
      end
      default: nextState = IDLE;
    endcase
    if (invalidateAll || abortFill) begin
      nextState = IDLE;
      allocate  = 1'b0;
      wordWrite = 1'b0;
      fillDone  = 1'b0;
    end
  end

  // Per-page tags, valid flags, fill counters and the round-robin victim.
  always_ff @(posedge clk) begin
    if (rst) begin
      tagValid <= '0;
      victim   <= '0;
      fillPage <= '0;
      for (int p = 0; p < int'(PAGE_COUNT); p++) begin
        tag[p]       <= '0;
        fillCount[p] <= '0;
      end
    end else begin
      if (allocate) begin
        fillPage          <= victim;
        tag[victim]       <= requestTag;
        tagValid[victim]  <= 1'b1;
        fillCount[victim] <= '0;
      end
      if (wordWrite) begin
        fillCount[fillPage] <= fillCount[fillPage] + COUNT_SIZE'(1);
      end
      if (fillDone) begin
        victim <= victim + PAGE_COUNT_LOG2'(1);
      end
      if (invalidateAll) begin
        tagValid <= '0;
      end else if (abortFill) begin
        tagValid[fillPage] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flash_cache_page_set.sv
// Bench for flash_cache_page_set: directed scenarios plus a randomized run
// against a cache-level reference model (pages, tags, word counts).
module tb_flash_cache_page_set;

  localparam int PC  = 8;
  localparam int WPP = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        qspi_enable;
  logic        invalidateAll;
  logic        readEnable;
  logic [23:0] readAddress;
  logic        wordReady;
  logic [8:0]  sramReadAddress;
  logic [8:0]  sramWriteAddress;
  logic        sramWriteEnable;
  logic [23:0] qspi_address;
  logic        qspi_changeAddress;
  logic        qspi_requestData;
  logic        qspi_readDataValid;
  logic        qspi_initialised;
  logic        qspi_busy;
  logic [7:0]  pageValidMask;
  logic        busy;

  int checks = 0;
  int errors = 0;

  flash_cache_page_set dut (
    .clk(clk), .rst(rst), .qspi_enable(qspi_enable), .invalidateAll(invalidateAll),
    .readEnable(readEnable), .readAddress(readAddress), .wordReady(wordReady),
    .sramReadAddress(sramReadAddress), .sramWriteAddress(sramWriteAddress),
    .sramWriteEnable(sramWriteEnable), .qspi_address(qspi_address),
    .qspi_changeAddress(qspi_changeAddress), .qspi_requestData(qspi_requestData),
    .qspi_readDataValid(qspi_readDataValid), .qspi_initialised(qspi_initialised),
    .qspi_busy(qspi_busy), .pageValidMask(pageValidMask), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: what each page holds and what the fill engine is doing.
  int mTag [PC];
  bit mValid [PC];
  int mCount [PC];
  int mVictim;
  int mFillPage;
  bit mAddrPhase;
  bit mFilling;

  bit         eReady, eChange, eReq, eWe, eBusy, eHit;
  int         eHitPage;
  logic [8:0] eRdAddr, eWrAddr;
  logic [23:0] eQAddr;
  logic [7:0] eMask;

  int obsStrobes;
  logic [23:0] obsQAddr;

  task automatic resetModel();
    for (int p = 0; p < PC; p++) begin
      mTag[p] = 0; mValid[p] = 0; mCount[p] = 0;
    end
    mVictim = 0; mFillPage = 0; mAddrPhase = 0; mFilling = 0;
  endtask

  task automatic evalModel();
    int t;
    int w;
    t = int'(readAddress[23:8]);
    w = int'(readAddress[7:2]);
    eHit = 0; eHitPage = 0;
    for (int p = 0; p < PC; p++)
      if (!eHit && mValid[p] && mTag[p] == t) begin eHit = 1; eHitPage = p; end
    eReady  = qspi_enable && qspi_initialised && readEnable && eHit && (w < mCount[eHitPage]);
    eRdAddr = 9'(eHitPage * WPP + w);
    eWrAddr = 9'(mFillPage * WPP + (mCount[mFillPage] % WPP));
    eQAddr  = 24'(mTag[mFillPage]) << 8;
    eChange = mAddrPhase && !qspi_busy;
    eReq    = mFilling;
    eWe     = mFilling && qspi_readDataValid;
    eBusy   = mAddrPhase || mFilling;
    for (int p = 0; p < PC; p++) eMask[p] = mValid[p];
  endtask

  task automatic updateModel();
    evalModel();
    if (rst) resetModel();
    else if (invalidateAll) begin
      for (int p = 0; p < PC; p++) mValid[p] = 0;
      mAddrPhase = 0; mFilling = 0;
    end else if ((mAddrPhase || mFilling) && !qspi_enable) begin
      mValid[mFillPage] = 0;
      mAddrPhase = 0; mFilling = 0;
    end else if (mAddrPhase) begin
      if (!qspi_busy) begin mAddrPhase = 0; mFilling = 1; end
    end else if (mFilling) begin
      if (qspi_readDataValid) begin
        mCount[mFillPage]++;
        if (mCount[mFillPage] == WPP) begin
          mFilling = 0;
          mVictim = (mVictim + 1) % PC;
        end
      end
    end else if (readEnable && !eHit && qspi_enable && qspi_initialised) begin
      mFillPage = mVictim;
      mTag[mVictim] = int'(readAddress[23:8]);
      mValid[mVictim] = 1;
      mCount[mVictim] = 0;
      mAddrPhase = 1;
    end
  endtask

  task automatic stepClk();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic settle();
    #1;
    evalModel();
  endtask

  task automatic doReset();
    rst = 1; invalidateAll = 0; readEnable = 0; qspi_readDataValid = 0;
    qspi_busy = 0; qspi_enable = 1; qspi_initialised = 1;
    stepClk();
    rst = 0;
  endtask

  // Miss on addr, let the strobe through, then deliver a whole page.
  task automatic doMissAndFill(input logic [23:0] addr);
    readEnable = 1; readAddress = addr; qspi_readDataValid = 0; qspi_busy = 0;
    obsStrobes = 0;
    stepClk();
    settle();
    if (qspi_changeAddress) obsStrobes++;
    obsQAddr = qspi_address;
    stepClk();
    qspi_readDataValid = 1;
    for (int i = 0; i < WPP; i++) begin
      #1;
      if (qspi_changeAddress) obsStrobes++;
      stepClk();
    end
    qspi_readDataValid = 0; readEnable = 0;
  endtask

  task automatic test_reset();
    rst = 1; invalidateAll = 0; readEnable = 0; qspi_readDataValid = 0;
    qspi_busy = 0; qspi_enable = 0; qspi_initialised = 0; readAddress = 24'h0000AC;
    stepClk();
    rst = 0;
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", busy); end
    checks++; if (pageValidMask !== 8'h00) begin errors++; $display("FAIL reset_mask got %0h want 0", pageValidMask); end
    checks++; if (qspi_changeAddress !== 1'b0) begin errors++; $display("FAIL reset_change got %0h want 0", qspi_changeAddress); end
    checks++; if (qspi_requestData !== 1'b0) begin errors++; $display("FAIL reset_req got %0h want 0", qspi_requestData); end
    checks++; if (sramWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %0h want 0", sramWriteEnable); end
    checks++; if (qspi_address !== 24'h0) begin errors++; $display("FAIL reset_qaddr got %0h want 0", qspi_address); end
    checks++; if (sramWriteAddress !== 9'h0) begin errors++; $display("FAIL reset_wraddr got %0h want 0", sramWriteAddress); end
    checks++; if (sramReadAddress !== 9'h02B) begin errors++; $display("FAIL reset_rdaddr got %0h want 2b", sramReadAddress); end
  endtask

  task automatic test_fill_basic();
    qspi_enable = 1; qspi_initialised = 1; qspi_busy = 0;
    readEnable = 1; readAddress = 24'h001000;
    settle();
    checks++; if (wordReady !== 1'b0) begin errors++; $display("FAIL miss_ready got %0h want 0", wordReady); end
    stepClk();
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL alloc_busy got %0h want 1", busy); end
    checks++; if (qspi_changeAddress !== 1'b1) begin errors++; $display("FAIL alloc_change got %0h want 1", qspi_changeAddress); end
    checks++; if (qspi_address !== 24'h001000) begin errors++; $display("FAIL alloc_qaddr got %0h want 1000", qspi_address); end
    stepClk();
    readAddress = 24'h001008; qspi_readDataValid = 1;
    for (int i = 0; i < WPP; i++) begin
      settle();
      checks++; if (sramWriteAddress !== 9'(i)) begin errors++; $display("FAIL fill_wraddr[%0d] got %0h want %0h", i, sramWriteAddress, 9'(i)); end
      checks++; if (sramWriteEnable !== 1'b1) begin errors++; $display("FAIL fill_we[%0d] got %0h want 1", i, sramWriteEnable); end
      checks++; if (wordReady !== 1'(i >= 3)) begin errors++; $display("FAIL critical_ready[%0d] got %0h want %0h", i, wordReady, (i >= 3)); end
      checks++; if (sramReadAddress !== 9'h002) begin errors++; $display("FAIL critical_rdaddr[%0d] got %0h want 2", i, sramReadAddress); end
      stepClk();
    end
    qspi_readDataValid = 0;
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_busy got %0h want 0", busy); end
    checks++; if (pageValidMask !== 8'h01) begin errors++; $display("FAIL done_mask got %0h want 01", pageValidMask); end
    checks++; if (qspi_requestData !== 1'b0) begin errors++; $display("FAIL done_req got %0h want 0", qspi_requestData); end
    checks++; if (wordReady !== 1'b1) begin errors++; $display("FAIL done_ready got %0h want 1", wordReady); end
    readEnable = 0;
  endtask

  task automatic test_round_robin();
    doReset();
    for (int k = 0; k < 9; k++) begin
      doMissAndFill(24'(k * 256));
      checks++; if (obsQAddr !== 24'(k * 256)) begin errors++; $display("FAIL rr_qaddr[%0d] got %0h want %0h", k, obsQAddr, 24'(k * 256)); end
      checks++; if (obsStrobes != 1) begin errors++; $display("FAIL rr_strobes[%0d] got %0d want 1", k, obsStrobes); end
      if (k == 7) begin
        settle();
        checks++; if (pageValidMask !== 8'hFF) begin errors++; $display("FAIL rr_full_mask got %0h want ff", pageValidMask); end
      end
    end
    readEnable = 1; readAddress = 24'h000800;
    settle();
    checks++; if (wordReady !== 1'b1) begin errors++; $display("FAIL rr_wrap_ready got %0h want 1", wordReady); end
    checks++; if (sramReadAddress !== 9'h000) begin errors++; $display("FAIL rr_wrap_rdaddr got %0h want 0", sramReadAddress); end
    readAddress = 24'h000704;
    settle();
    checks++; if (sramReadAddress !== 9'h1C1) begin errors++; $display("FAIL rr_page7_rdaddr got %0h want 1c1", sramReadAddress); end
    readAddress = 24'h000000;
    settle();
    checks++; if (wordReady !== 1'b0) begin errors++; $display("FAIL rr_evicted_ready got %0h want 0", wordReady); end
    stepClk();
    settle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rr_refetch_busy got %0h want 1", busy); end
    checks++; if (sramWriteAddress !== 9'h040) begin errors++; $display("FAIL rr_refetch_wraddr got %0h want 40", sramWriteAddress); end
    readEnable = 0;
  endtask

  task automatic test_concurrent_miss();
    doReset();
    doMissAndFill(24'h002000);
    readEnable = 1; readAddress = 24'h003000;
    stepClk();
    settle();
    checks++; if (qspi_address !== 24'h003000) begin errors++; $display("FAIL cm_qaddr1 got %0h want 3000", qspi_address); end
    stepClk();
    readAddress = 24'h004000; qspi_readDataValid = 1;
    for (int i = 0; i < WPP; i++) begin
      settle();
      checks++; if (qspi_changeAddress !== 1'b0) begin errors++; $display("FAIL cm_wait_change[%0d] got %0h want 0", i, qspi_changeAddress); end
      checks++; if (wordReady !== 1'b0) begin errors++; $display("FAIL cm_wait_ready[%0d] got %0h want 0", i, wordReady); end
      checks++; if (sramWriteAddress !== 9'(64 + i)) begin errors++; $display("FAIL cm_wraddr[%0d] got %0h want %0h", i, sramWriteAddress, 9'(64 + i)); end
      stepClk();
    end
    qspi_readDataValid = 0;
    settle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cm_idle_busy got %0h want 0", busy); end
    checks++; if (pageValidMask !== 8'h03) begin errors++; $display("FAIL cm_mask got %0h want 03", pageValidMask); end
    stepClk();
    settle();
    checks++; if (qspi_changeAddress !== 1'b1) begin errors++; $display("FAIL cm_change2 got %0h want 1", qspi_changeAddress); end
    checks++; if (qspi_address !== 24'h004000) begin errors++; $display("FAIL cm_qaddr2 got %0h want 4000", qspi_address); end
    checks++; if (sramWriteAddress !== 9'h080) begin errors++; $display("FAIL cm_page2_wraddr got %0h want 80", sramWriteAddress); end
    readEnable = 0;
  endtask

  task automatic test_invalidate();
    doReset();
    readEnable = 1; readAddress = 24'h005000;
    stepClk();
    stepClk();
    qspi_readDataValid = 1;
    repeat (10) stepClk();
    invalidateAll = 1;
    settle();
    checks++; if (sramWriteEnable !== 1'b1) begin errors++; $display("FAIL inv_we got %0h want 1", sramWriteEnable); end
    checks++; if (sramWriteAddress !== 9'd10) begin errors++; $display("FAIL inv_wraddr got %0h want a", sramWriteAddress); end
    stepClk();
    invalidateAll = 0; qspi_readDataValid = 0; readEnable = 0;
    settle();
    checks++; if (pageValidMask !== 8'h00) begin errors++; $display("FAIL inv_mask got %0h want 0", pageValidMask); end
    checks++; if (qspi_requestData !== 1'b0) begin errors++; $display("FAIL inv_req got %0h want 0", qspi_requestData); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL inv_busy got %0h want 0", busy); end
    checks++; if (sramWriteAddress !== 9'd10) begin errors++; $display("FAIL inv_count_held got %0h want a", sramWriteAddress); end
    readEnable = 1;
    settle();
    checks++; if (wordReady !== 1'b0) begin errors++; $display("FAIL inv_reread_ready got %0h want 0", wordReady); end
    stepClk();
    settle();
    checks++; if (qspi_changeAddress !== 1'b1) begin errors++; $display("FAIL inv_refetch_change got %0h want 1", qspi_changeAddress); end
    checks++; if (qspi_address !== 24'h005000) begin errors++; $display("FAIL inv_refetch_qaddr got %0h want 5000", qspi_address); end
    checks++; if (sramWriteAddress !== 9'h000) begin errors++; $display("FAIL inv_refetch_wraddr got %0h want 0", sramWriteAddress); end
    readEnable = 0;
  endtask

  task automatic test_busy_enable();
    doReset();
    qspi_busy = 1; readEnable = 1; readAddress = 24'h006000;
    stepClk();
    readEnable = 0;
    repeat (5) begin
      settle();
      checks++; if (qspi_changeAddress !== 1'b0) begin errors++; $display("FAIL qbusy_change got %0h want 0", qspi_changeAddress); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL qbusy_busy got %0h want 1", busy); end
      stepClk();
    end
    qspi_busy = 0;
    settle();
    checks++; if (qspi_changeAddress !== 1'b1) begin errors++; $display("FAIL qbusy_release got %0h want 1", qspi_changeAddress); end
    stepClk();
    obsStrobes = 0;
    qspi_readDataValid = 1;
    for (int i = 0; i < WPP; i++) begin
      #1;
      if (qspi_changeAddress) obsStrobes++;
      stepClk();
    end
    qspi_readDataValid = 0;
    settle();
    checks++; if (obsStrobes != 0) begin errors++; $display("FAIL qbusy_extra_strobes got %0d want 0", obsStrobes); end
    checks++; if (pageValidMask !== 8'h01) begin errors++; $display("FAIL en_first_mask got %0h want 01", pageValidMask); end
    readEnable = 1; readAddress = 24'h007000;
    stepClk();
    stepClk();
    qspi_readDataValid = 1;
    repeat (5) stepClk();
    qspi_readDataValid = 0; qspi_enable = 0;
    settle();
    checks++; if (pageValidMask !== 8'h03) begin errors++; $display("FAIL en_prefall_mask got %0h want 03", pageValidMask); end
    stepClk();
    readAddress = 24'h006000;
    settle();
    checks++; if (pageValidMask !== 8'h01) begin errors++; $display("FAIL en_fall_mask got %0h want 01", pageValidMask); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL en_fall_busy got %0h want 0", busy); end
    checks++; if (qspi_requestData !== 1'b0) begin errors++; $display("FAIL en_fall_req got %0h want 0", qspi_requestData); end
    checks++; if (wordReady !== 1'b0) begin errors++; $display("FAIL en_off_ready got %0h want 0", wordReady); end
    qspi_enable = 1;
    settle();
    checks++; if (wordReady !== 1'b1) begin errors++; $display("FAIL en_on_ready got %0h want 1", wordReady); end
    readEnable = 0;
  endtask

  task automatic test_random();
    int startErrors;
    doReset();
    startErrors = errors;
    for (int c = 0; c < 4000 && errors == startErrors; c++) begin
      readEnable         = ($urandom_range(0, 3) != 0);
      readAddress        = (24'($urandom_range(0, 11) * 19) << 8) | 24'($urandom_range(0, 255));
      qspi_readDataValid = ($urandom_range(0, 9) < 7);
      qspi_busy          = ($urandom_range(0, 9) < 3);
      invalidateAll      = ($urandom_range(0, 199) == 0);
      qspi_enable        = ($urandom_range(0, 149) != 0);
      qspi_initialised   = ($urandom_range(0, 49) != 0);
      settle();
      checks++; if (wordReady !== eReady) begin errors++; $display("FAIL rnd_ready c%0d got %0h want %0h", c, wordReady, eReady); end
      checks++; if (sramReadAddress !== eRdAddr) begin errors++; $display("FAIL rnd_rdaddr c%0d got %0h want %0h", c, sramReadAddress, eRdAddr); end
      checks++; if (sramWriteAddress !== eWrAddr) begin errors++; $display("FAIL rnd_wraddr c%0d got %0h want %0h", c, sramWriteAddress, eWrAddr); end
      checks++; if (sramWriteEnable !== eWe) begin errors++; $display("FAIL rnd_we c%0d got %0h want %0h", c, sramWriteEnable, eWe); end
      checks++; if (qspi_address !== eQAddr) begin errors++; $display("FAIL rnd_qaddr c%0d got %0h want %0h", c, qspi_address, eQAddr); end
      checks++; if (qspi_changeAddress !== eChange) begin errors++; $display("FAIL rnd_change c%0d got %0h want %0h", c, qspi_changeAddress, eChange); end
      checks++; if (qspi_requestData !== eReq) begin errors++; $display("FAIL rnd_req c%0d got %0h want %0h", c, qspi_requestData, eReq); end
      checks++; if (pageValidMask !== eMask) begin errors++; $display("FAIL rnd_mask c%0d got %0h want %0h", c, pageValidMask, eMask); end
      checks++; if (busy !== eBusy) begin errors++; $display("FAIL rnd_busy c%0d got %0h want %0h", c, busy, eBusy); end
      stepClk();
    end
    invalidateAll = 0; readEnable = 0; qspi_readDataValid = 0;
  endtask

  initial begin
    resetModel();
    test_reset();
    test_fill_basic();
    test_round_robin();
    test_concurrent_miss();
    test_invalidate();
    test_busy_enable();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/flash_cache_page_set.md
Name: flash_cache_page_set

Overview:
- Parametrised successor to the single flash cache page: one block manages PAGE_COUNT pages of one shared cache SRAM.
- Provides fully-associative tag lookup, round-robin victim selection and a single arbitrated QSPI fill engine.
- Sits between the flash read port (instruction/data fetch) and the QSPI flash controller, and drives both SRAM address ports.

Parameters:
- ADDRESS_SIZE, 24, byte address width of the flash space.
- PAGE_COUNT_LOG2, 3, log2 of the number of pages (PAGE_COUNT = 1<<PAGE_COUNT_LOG2).
- WORDS_PER_PAGE_LOG2, 6, log2 of the number of 32-bit words per page.
- Derived, not overridable:
  - SRAM_ADDRESS_SIZE = PAGE_COUNT_LOG2+WORDS_PER_PAGE_LOG2.
  - TAG_SIZE = ADDRESS_SIZE-WORDS_PER_PAGE_LOG2-2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- qspi_enable  in  1  flash cache enabled.
- invalidateAll  in  1  one-cycle pulse; drop all pages.
- readEnable  in  1  read request present.
- readAddress  in  ADDRESS_SIZE  byte address of the request.
- wordReady  out  1  requested word is present in SRAM.
- sramReadAddress  out  SRAM_ADDRESS_SIZE  {hit page, readAddress[WORDS_PER_PAGE_LOG2+1:2]}.
- sramWriteAddress  out  SRAM_ADDRESS_SIZE  {fill page, fill word counter}.
- sramWriteEnable  out  1  = qspi_requestData && qspi_readDataValid && state==FILL.
- qspi_address  out  ADDRESS_SIZE  {fill tag, zeros, 2'b00}.
- qspi_changeAddress  out  1  one-cycle base-address load strobe.
- qspi_requestData  out  1  fill engine wants the next word.
- qspi_readDataValid  in  1  QSPI word valid this cycle.
- qspi_initialised  in  1  flash device initialised.
- qspi_busy  in  1  QSPI controller cannot take an address change.
- pageValidMask  out  PAGE_COUNT  per-page tag-valid flags.
- busy  out  1  state != IDLE.

Behaviour:
- Per-page state: tag[TAG_SIZE], tagValid, fillCount[WORDS_PER_PAGE_LOG2+1].
- Reset: all tagValid=0, all fillCount=0, victim pointer=0, state=IDLE.
- Reset output values: all outputs 0 except the address outputs, which follow their formulas with zero state (sramReadAddress follows readAddress).
- Hit, page p: tagValid[p] && tag[p]==readAddress[ADDRESS_SIZE-1:WORDS_PER_PAGE_LOG2+2].
  - At most one page hits; the tag write rule guarantees this.
- wordReady: combinational, same cycle = qspi_enable && qspi_initialised && readEnable && hit && (word index < fillCount[p]). No added latency.
- Hit page for sramReadAddress: lowest-index hitting page; 0 when no hit.
- FSM states: IDLE, CHANGE_ADDR, FILL.
- IDLE -> CHANGE_ADDR: readEnable && !hit && qspi_enable && qspi_initialised. On this transition:
  - fill page = victim pointer; tag = request tag; tagValid=1; fillCount=0.
  - A page that hits with partial data is never re-allocated.
- CHANGE_ADDR: qspi_changeAddress = !qspi_busy. After the strobe cycle -> FILL.
- FILL:
  - qspi_requestData=1.
  - Each qspi_readDataValid: write word, fillCount++.
  - When fillCount reaches 1<<WORDS_PER_PAGE_LOG2: requestData drops the same edge, victim pointer increments (wraps at PAGE_COUNT), -> IDLE.
- Critical-word behaviour: a request to the filling page is ready as soon as its word index < fillCount. Fill order is linear from word 0.
- A miss on another page during CHANGE_ADDR/FILL waits: wordReady=0 and no allocation until return to IDLE. The miss is then serviced next cycle.
- Abort (invalidateAll, or qspi_enable falling, in any state):
  - all tagValid=0 (invalidateAll), or only the fill page tagValid=0 (enable falling);
  - state=IDLE next cycle; requestData low next cycle; victim pointer unchanged.
- invalidateAll coincident with qspi_readDataValid: invalidate wins; fillCount not incremented; sramWriteEnable still follows its formula (the write is harmless).
- invalidateAll coincident with a new miss in IDLE: invalidate wins; allocation happens on a later cycle.
- Victim pointer wraps PAGE_COUNT-1 -> 0. Replacement ignores page use; this is pure round-robin.
- All counters/pointers are unsigned modulo their width. fillCount's extra bit holds the full value without overflow.

Test Plan:
- Reset, then readEnable with readAddress=0x001000 -> next cycle busy=1, state CHANGE_ADDR. With qspi_busy=0, qspi_changeAddress pulses with qspi_address=0x001000. Then 64 readDataValid pulses -> sramWriteAddress steps 0..63, pageValidMask=8'h01, busy=0.
- Mid-fill critical word: during the above fill, read 0x001008 (word 2) -> wordReady=0 until the 3rd readDataValid, then 1 in the following cycle. sramReadAddress=9'h002.
- Round-robin wrap: miss 9 distinct pages (0x000000, 0x000100, ...) -> pages 0..7 fill. The 9th allocates page 0 with tag 0x0800/0x100 layout; the original page-0 address then misses.
- Concurrent miss: during a page-1 fill, request a new page -> no changeAddress until the fill completes. Then changeAddress one cycle after returning to IDLE, filling page 2.
- invalidateAll mid-fill, coincident with readDataValid -> pageValidMask=0 next cycle, requestData=0, fillCount not incremented, a re-read of the same address re-fetches from word 0.
- qspi_busy held high 5 cycles in CHANGE_ADDR -> changeAddress stays low, then pulses exactly once when busy drops. qspi_enable falling mid-fill clears only that page's valid bit.
